// File: rtl/aes_cbc_ctrl.sv
// CBC-mode sequencer in front of a single aes_top: key load, block issue, chaining XOR, output hold.
// Optional key caching is compiled in with `define AES_CBC_CTRL_KEY_CACHE_EN.
module aes_cbc_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_decrypt,
    input  logic         s_first,
    input  logic [127:0] s_iv,
    input  logic [127:0] s_key,
    input  logic [127:0] s_blk,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_blk,
    output logic         aes_en,
    output logic [31:0]  aes_cmd,
    output logic [127:0] aes_key,
    output logic [127:0] aes_in_blk,
    input  logic [127:0] aes_out_blk,
    input  logic         aes_en_o,
    output logic         busy
);
    localparam logic [31:0] SET_KEY_128     = 32'h0000_0001;
    localparam logic [31:0] ECB_ENCRYPT_128 = 32'h0000_0002;
    localparam logic [31:0] ECB_DECRYPT_128 = 32'h0000_0003;

    typedef enum logic [2:0] {IDLE, KEY_ISSUE, KEY_WAIT, BLK_ISSUE, BLK_WAIT, OUT} state_t;

    state_t        state_q, state_d;
    logic          decrypt_q, decrypt_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  blk_q, blk_d;
    logic [127:0]  chain_q, chain_d;
    logic [127:0]  m_blk_q, m_blk_d;
    logic [31:0]   aes_cmd_q, aes_cmd_d;
    logic [127:0]  aes_key_q, aes_key_d;
    logic [127:0]  aes_in_blk_q, aes_in_blk_d;
    logic          need_key;

    // Block operands seen at issue time: live inputs when issuing straight from IDLE, captured otherwise.
    logic          issue_dec;
    logic [127:0]  issue_blk, issue_chain;
    logic [31:0]   blk_cmd;
    logic [127:0]  blk_in;

`ifdef AES_CBC_CTRL_KEY_CACHE_EN
    logic          key_loaded_q;
    logic [127:0]  cached_key_q;

    assign need_key = !key_loaded_q || (s_key != cached_key_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            key_loaded_q <= 1'b0;
            cached_key_q <= '0;
        end else if (state_q == KEY_WAIT && aes_en_o) begin
            key_loaded_q <= 1'b1;
            cached_key_q <= key_q;
        end
    end
`else
    assign need_key = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            decrypt_q    <= 1'b0;
            key_q        <= '0;
            blk_q        <= '0;
            chain_q      <= '0;
            m_blk_q      <= '0;
            aes_cmd_q    <= '0;
            aes_key_q    <= '0;
            aes_in_blk_q <= '0;
        end else begin
            state_q      <= state_d;
            decrypt_q    <= decrypt_d;
            key_q        <= key_d;
            blk_q        <= blk_d;
            chain_q      <= chain_d;
            m_blk_q      <= m_blk_d;
            aes_cmd_q    <= aes_cmd_d;
            aes_key_q    <= aes_key_d;
            aes_in_blk_q <= aes_in_blk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (s_valid) state_d = need_key ? KEY_ISSUE : BLK_ISSUE;
            KEY_ISSUE: state_d = KEY_WAIT;
            KEY_WAIT:  if (aes_en_o) state_d = BLK_ISSUE;
            BLK_ISSUE: state_d = BLK_WAIT;
            BLK_WAIT:  if (aes_en_o) state_d = OUT;
            OUT:       if (m_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_q == IDLE);
        m_valid = (state_q == OUT);
        aes_en  = (state_q == KEY_ISSUE) || (state_q == BLK_ISSUE);
        busy    = (state_q != IDLE);
    end

    always_comb begin
        decrypt_d    = decrypt_q;
        key_d        = key_q;
        blk_d        = blk_q;
        chain_d      = chain_q;
        m_blk_d      = m_blk_q;
        aes_cmd_d    = aes_cmd_q;
        aes_key_d    = aes_key_q;
        aes_in_blk_d = aes_in_blk_q;

        issue_dec   = decrypt_q;
        issue_blk   = blk_q;
        issue_chain = chain_q;
        if (state_q == IDLE) begin
            issue_dec   = s_decrypt;
            issue_blk   = s_blk;
            issue_chain = s_first ? s_iv : chain_q;
        end
        blk_cmd = issue_dec ? ECB_DECRYPT_128 : ECB_ENCRYPT_128;
        blk_in  = issue_dec ? issue_blk : (issue_blk ^ issue_chain);

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    decrypt_d = s_decrypt;
                    key_d     = s_key;
                    blk_d     = s_blk;
                    chain_d   = issue_chain;
                    aes_key_d = s_key;
                    if (need_key) begin
                        aes_cmd_d = SET_KEY_128;
                    end else begin
                        aes_cmd_d    = blk_cmd;
                        aes_in_blk_d = blk_in;
                    end
                end
            end
            KEY_WAIT: begin
                if (aes_en_o) begin
                    aes_cmd_d    = blk_cmd;
                    aes_in_blk_d = blk_in;
                end
            end
            BLK_WAIT: begin
                // Decrypt chains on the ciphertext that came in, encrypt on the one that goes out.
                if (aes_en_o) begin
                    m_blk_d = decrypt_q ? (aes_out_blk ^ chain_q) : aes_out_blk;
                    chain_d = decrypt_q ? blk_q : aes_out_blk;
                end
            end
            default: ;
        endcase
    end

    assign m_blk      = m_blk_q;
    assign aes_cmd    = aes_cmd_q;
    assign aes_key    = aes_key_q;
    assign aes_in_blk = aes_in_blk_q;

endmodule
